div_gen: RTL and testbench

Parametrised multi-cycle integer divider that replaces the fixed 32-bit divider driven by the EX stage. It accepts a start request with two WIDTH-bit operands, produces quotient and remainder via restoring division at one bit per cycle, and holds the result until EX drops its request. Over the fixed 32-bit divider it adds a WIDTH parameter, a divide-by-zero flag, a busy indication, and abort on either `annul_i` or `start_i` deassertion.

---
 rtl/div_gen.sv | 173 +++++++++++++++++
 tb/tb_div_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_gen.sv
// Multi-cycle restoring integer divider (signed/unsigned) with divide-by-zero flag and abort.
// Latency: WIDTH+1 cycles from the start edge to ready_o (1 cycle for a zero divisor).
// Backpressure: requester holds start_i high; the result is held until start_i falls.
module div_gen #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 divzero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    // Partial remainder is one bit wider than the operands; its top bit stays 0.
    logic [WIDTH:0]       rem_q, rem_d;
    // Holds the dividend magnitude; quotient bits shift in from the bottom as dividend bits leave the top.
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dsr_q, dsr_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 divzero_q, divzero_d;

    logic [WIDTH-1:0]     abs1, abs2;
    logic [WIDTH+1:0]     shifted, trial;
    logic [WIDTH-1:0]     quo_fin, rem_fin;
    logic                 abort;

    // Operand magnitudes, one restoring trial subtraction, and sign-corrected final values.
    always_comb begin
        abs1    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs2    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {2'b00, dsr_q};
        quo_fin = negq_q ? -quo_q : quo_q;
        rem_fin = negr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        abort   = annul_i || !start_i;
    end

    // Next-state and next-output logic; every register defaults to holding its value.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dsr_d     = dsr_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        result_d  = result_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        divzero_d = divzero_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    busy_d = 1'b1;
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d = S_ON;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = abs1;
                        dsr_d   = abs2;
                        negq_d  = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        negr_d  = signed_div_i && opdata1_i[WIDTH-1];
                    end
                end
            end
            S_BYZERO: begin
                busy_d   = 1'b0;
                result_d = '0;
                if (abort) begin
                    state_d   = S_IDLE;
                    ready_d   = 1'b0;
                    divzero_d = 1'b0;
                end else begin
                    state_d   = S_END;
                    ready_d   = 1'b1;
                    divzero_d = 1'b1;
                end
            end
            S_ON: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    result_d  = '0;
                    ready_d   = 1'b0;
                    divzero_d = 1'b0;
                end else if (cnt_q == CW'(WIDTH)) begin
                    state_d   = S_END;
                    busy_d    = 1'b0;
                    result_d  = {rem_fin, quo_fin};
                    ready_d   = 1'b1;
                    divzero_d = 1'b0;
                end else begin
                    // A clear top bit of the trial means the divisor fitted: keep the difference.
                    if (!trial[WIDTH+1]) begin
                        rem_d = trial[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_d   = S_IDLE;
                    result_d  = '0;
                    ready_d   = 1'b0;
                    divzero_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dsr_q     <= dsr_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            divzero_q <= divzero_d;
        end
    end

    assign result_o  = result_q;
    assign ready_o   = ready_q;
    assign busy_o    = busy_q;
    assign divzero_o = divzero_q;

endmodule

// File: tb/tb_div_gen.sv
// Bench for div_gen: a 32-bit and an 8-bit instance checked against an arithmetic reference.
// Latency: checks WIDTH+1 cycles to ready (1 for zero divisor) and busy duration.
// Backpressure: start is held through END; result hold and clear on start drop are checked.
module tb_div_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start32, start8, annul, sgn;
    logic [31:0] a, b;
    logic [63:0] res32;
    logic [15:0] res8;
    logic        rdy32, bsy32, dz32, rdy8, bsy8, dz8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_gen #(.WIDTH(32)) u_div32 (
        .clk(clk), .rst(rst), .start_i(start32), .annul_i(annul), .signed_div_i(sgn),
        .opdata1_i(a), .opdata2_i(b),
        .result_o(res32), .ready_o(rdy32), .busy_o(bsy32), .divzero_o(dz32)
    );

    div_gen #(.WIDTH(8)) u_div8 (
        .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul), .signed_div_i(sgn),
        .opdata1_i(a[7:0]), .opdata2_i(b[7:0]),
        .result_o(res8), .ready_o(rdy8), .busy_o(bsy8), .divzero_o(dz8)
    );

    function automatic logic [63:0] cur_res(input int w);
        return (w == 32) ? res32 : {48'd0, res8};
    endfunction
    function automatic logic cur_rdy(input int w);
        return (w == 32) ? rdy32 : rdy8;
    endfunction
    function automatic logic cur_bsy(input int w);
        return (w == 32) ? bsy32 : bsy8;
    endfunction
    function automatic logic cur_dz(input int w);
        return (w == 32) ? dz32 : dz8;
    endfunction

    // Reference: 64-bit arithmetic division (truncating), packed as {rem, quo} at width w.
    function automatic void model(input int w, input logic [31:0] x, input logic [31:0] y,
                                  input bit s, output logic [63:0] r, output bit dz);
        longint mask, xv, yv, q, m;
        mask = (longint'(1) << w) - 1;
        xv   = longint'({32'd0, x}) & mask;
        yv   = longint'({32'd0, y}) & mask;
        if (s && xv[w-1]) xv = xv - (longint'(1) << w);
        if (s && yv[w-1]) yv = yv - (longint'(1) << w);
        dz = (yv == 0);
        if (dz) begin
            r = '0;
        end else begin
            q = xv / yv;
            m = xv % yv;
            r = ((m & mask) << w) | (q & mask);
        end
    endfunction

    task automatic do_op(input int w, input logic [31:0] x, input logic [31:0] y, input bit s);
        logic [63:0] exp_res;
        logic [63:0] held;
        bit          exp_dz;
        bit          got;
        int          lat, bcnt, exp_lat;
        model(w, x, y, s, exp_res, exp_dz);
        exp_lat = exp_dz ? 1 : w + 1;
        a = x; b = y; sgn = s; annul = 1'b0;
        if (w == 32) start32 = 1'b1; else start8 = 1'b1;
        got = 0; lat = 0; bcnt = 0;
        for (int k = 0; k < w + 10 && !got; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                // operands after the start edge must not matter
                a = $urandom; b = $urandom; sgn = 1'($urandom);
            end
            if (cur_bsy(w)) bcnt++;
            if (cur_rdy(w)) begin got = 1; lat = k; end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL timeout w=%0d %h/%h s=%0d: ready never rose", w, x, y, s);
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL latency w=%0d %h/%h: got %0d want %0d", w, x, y, lat, exp_lat);
        end
        n_cmp++;
        if (bcnt !== exp_lat) begin
            n_bad++;
            $display("FAIL busy_cycles w=%0d %h/%h: got %0d want %0d", w, x, y, bcnt, exp_lat);
        end
        n_cmp++;
        if (cur_res(w) !== exp_res) begin
            n_bad++;
            $display("FAIL result w=%0d %h/%h s=%0d: got %h want %h", w, x, y, s, cur_res(w), exp_res);
        end
        n_cmp++;
        if (cur_dz(w) !== exp_dz) begin
            n_bad++;
            $display("FAIL divzero w=%0d %h/%h: got %0b want %0b", w, x, y, cur_dz(w), exp_dz);
        end
        // END must hold while start stays high, ignoring annul
        held = cur_res(w);
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        n_cmp++;
        if (cur_rdy(w) !== 1'b1 || cur_res(w) !== exp_res || cur_dz(w) !== exp_dz) begin
            n_bad++;
            $display("FAIL hold w=%0d: rdy=%0b res=%h dz=%0b want rdy=1 res=%h dz=%0b",
                     w, cur_rdy(w), cur_res(w), cur_dz(w), held, exp_dz);
        end
        if (w == 32) start32 = 1'b0; else start8 = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (cur_rdy(w) !== 1'b0 || cur_res(w) !== 64'd0 || cur_dz(w) !== 1'b0 || cur_bsy(w) !== 1'b0) begin
            n_bad++;
            $display("FAIL clear w=%0d: rdy=%0b res=%h dz=%0b busy=%0b want all 0",
                     w, cur_rdy(w), cur_res(w), cur_dz(w), cur_bsy(w));
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start32 = 1'b0; start8 = 1'b0; annul = 1'b0; sgn = 1'b0;
        a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (res32 !== 64'd0 || rdy32 !== 1'b0 || bsy32 !== 1'b0 || dz32 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset32: res=%h rdy=%0b busy=%0b dz=%0b want 0", res32, rdy32, bsy32, dz32);
        end
        n_cmp++;
        if (res8 !== 16'd0 || rdy8 !== 1'b0 || bsy8 !== 1'b0 || dz8 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset8: res=%h rdy=%0b busy=%0b dz=%0b want 0", res8, rdy8, bsy8, dz8);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        do_op(32, 32'd7, 32'd2, 1'b0);
        do_op(32, 32'hFFFFFFF9, 32'd2, 1'b1);
        do_op(32, 32'd7, 32'hFFFFFFFE, 1'b1);
        do_op(32, 32'h12345678, 32'd0, 1'b0);
        do_op(32, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        do_op(32, 32'hFFFFFFFF, 32'd1, 1'b0);
        do_op(32, 32'h00000003, 32'hFFFFFFFF, 1'b0);
        do_op(8, 32'h80, 32'd3, 1'b1);
        do_op(8, 32'h80, 32'hFF, 1'b1);
        do_op(8, 32'hFF, 32'd0, 1'b1);
    endtask

    task automatic test_abort(input bit use_annul, input int at);
        bit saw;
        saw = 0;
        a = $urandom; b = 32'd5; sgn = 1'b0; annul = 1'b0; start32 = 1'b1;
        for (int k = 0; k <= at; k++) begin
            @(posedge clk); #1;
            if (rdy32) saw = 1;
        end
        if (use_annul) annul = 1'b1; else start32 = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bsy32 !== 1'b0 || rdy32 !== 1'b0 || res32 !== 64'd0 || saw) begin
            n_bad++;
            $display("FAIL abort annul=%0b at=%0d: busy=%0b rdy=%0b res=%h early_rdy=%0b want 0",
                     use_annul, at, bsy32, rdy32, res32, saw);
        end
        annul = 1'b0; start32 = 1'b0;
        @(posedge clk); #1;
        do_op(32, 32'd100, 32'd7, 1'b0);
    endtask

    task automatic test_reset_mid_on;
        a = 32'h55; b = 32'h3; sgn = 1'b0; start8 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (res8 !== 16'd0 || rdy8 !== 1'b0 || bsy8 !== 1'b0 || dz8 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_on: res=%h rdy=%0b busy=%0b dz=%0b want 0", res8, rdy8, bsy8, dz8);
        end
        rst = 1'b1; start8 = 1'b0;
        @(posedge clk); #1;
        do_op(8, 32'h80, 32'd3, 1'b1);
    endtask

    task automatic test_random(input int w, input int n);
        logic [31:0] x, y;
        for (int i = 0; i < n; i++) begin
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1, 2:    y = $urandom_range(1, 9);
                3:       y = 32'hFFFFFFFF - $urandom_range(0, 3);
                default: y = $urandom;
            endcase
            if (w == 8 && y[7:0] == 8'd0 && ($urandom_range(0, 1) == 1)) y[0] = 1'b1;
            do_op(w, x, y, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort(1'b1, 10);
        test_abort(1'b0, 20);
        test_reset_mid_on();
        test_random(32, 30);
        test_random(8, 25);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
